// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
// Time-multiplexing scan controller for a 4-digit seven-segment decoder.
// It generates an active-low one-hot anode scan, a per-digit brightness PWM
// and a short all-dark dead time at the start of each digit slot. The four
// displayed nibbles are double-buffered, so new values reach the decoder
// only on a frame boundary, or at once while scanning is disabled.
//
// Ports
//   clk         system clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   en          1 = scanning enabled; 0 = dark, counters held at zero
//   dig_mask    per-digit enable, bit d enables digit d
//   bright      duty: digit lit for (bright+1)/16 of its slot
//   load        one-cycle strobe capturing A_in..AminusB_in
//   A_in..AminusB_in   new values for digits 0..3
//   A..AminusB  displayed values for digits 0..3 (registered)
//   anode       active-low one-hot digit enable (registered)
//   frame_tick  one-cycle pulse after each frame boundary
//   pending     shadow holds values not yet displayed
module seven_seg_scan_ctrl #(
  parameter int SUB_CYCLES  = 6250,
  parameter int DEAD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] dig_mask,
  input  logic [3:0] bright,
  input  logic       load,
  input  logic [3:0] A_in,
  input  logic [3:0] B_in,
  input  logic [3:0] AplusB_in,
  input  logic [3:0] AminusB_in,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [3:0] AplusB,
  output logic [3:0] AminusB,
  output logic [3:0] anode,
  output logic       frame_tick,
  output logic       pending
);

  localparam int SUB_W = (SUB_CYCLES > 2) ? $clog2(SUB_CYCLES) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_CYCLES - 1);
  localparam logic [SUB_W-1:0] DEAD_LIM = SUB_W'(DEAD_CYCLES);

  // Active-low one-hot anode pattern for a digit index.
  function automatic logic [3:0] anode_code(input logic [1:0] d);
    logic [3:0] code;
    case (d)
      2'd0:    code = 4'b1110;
      2'd1:    code = 4'b1101;
      2'd2:    code = 4'b1011;
      2'd3:    code = 4'b0111;
      default: code = 4'b1111;
    endcase
    return code;
  endfunction

  logic [SUB_W-1:0] sub_cnt_r;
  logic [3:0]       phase_r;
  logic [1:0]       digit_r;
  logic [3:0]       anode_r;
  logic             frame_tick_r;
  logic             pending_r;
  logic [3:0]       a_r, b_r, sum_r, diff_r;
  logic [3:0]       a_sh_r, b_sh_r, sum_sh_r, diff_sh_r;

  logic [SUB_W-1:0] sub_cnt_next_s;
  logic [3:0]       phase_next_s;
  logic [1:0]       digit_next_s;
  logic             boundary_s;
  logic             transfer_s;
  logic             dead_s;
  logic             lit_s;
  logic [3:0]       anode_next_s;

  // Counter advance, frame boundary detection and anode selection.
  always_comb begin
    sub_cnt_next_s = '0;
    phase_next_s   = 4'd0;
    digit_next_s   = 2'd0;
    boundary_s     = 1'b0;
    dead_s         = 1'b0;
    lit_s          = 1'b0;
    anode_next_s   = 4'b1111;

    if (en) begin
      if (sub_cnt_r == SUB_LAST) begin
        sub_cnt_next_s = '0;
        if (phase_r == 4'd15) begin
          phase_next_s = 4'd0;
          digit_next_s = digit_r + 2'd1;  // 3 -> 0 wraps naturally
        end else begin
          phase_next_s = phase_r + 4'd1;
          digit_next_s = digit_r;
        end
      end else begin
        sub_cnt_next_s = sub_cnt_r + SUB_W'(1);
        phase_next_s   = phase_r;
        digit_next_s   = digit_r;
      end
      boundary_s = (digit_r == 2'd3) && (phase_r == 4'd15) && (sub_cnt_r == SUB_LAST);
      dead_s     = (phase_r == 4'd0) && (sub_cnt_r < DEAD_LIM);
      lit_s      = dig_mask[digit_r] && (phase_r <= bright) && !dead_s;
    end else begin
      sub_cnt_next_s = '0;
      phase_next_s   = 4'd0;
      digit_next_s   = 2'd0;
    end

    if (lit_s) begin
      anode_next_s = anode_code(digit_r);
    end else begin
      anode_next_s = 4'b1111;
    end

    // With scanning off nothing is being shown, so an update cannot tear.
    transfer_s = boundary_s || !en;
  end

  // Scan counters, anode register and frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_cnt_r    <= '0;
      phase_r      <= 4'd0;
      digit_r      <= 2'd0;
      anode_r      <= 4'b1111;
      frame_tick_r <= 1'b0;
    end else begin
      sub_cnt_r    <= sub_cnt_next_s;
      phase_r      <= phase_next_s;
      digit_r      <= digit_next_s;
      anode_r      <= anode_next_s;
      frame_tick_r <= boundary_s;
    end
  end

  // Shadow capture and tear-free transfer to the displayed values.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= 4'd0;
      b_r       <= 4'd0;
      sum_r     <= 4'd0;
      diff_r    <= 4'd0;
      a_sh_r    <= 4'd0;
      b_sh_r    <= 4'd0;
      sum_sh_r  <= 4'd0;
      diff_sh_r <= 4'd0;
      pending_r <= 1'b0;
    end else if (load) begin
      a_sh_r    <= A_in;
      b_sh_r    <= B_in;
      sum_sh_r  <= AplusB_in;
      diff_sh_r <= AminusB_in;
      if (transfer_s) begin
        a_r       <= A_in;
        b_r       <= B_in;
        sum_r     <= AplusB_in;
        diff_r    <= AminusB_in;
        pending_r <= 1'b0;
      end else begin
        pending_r <= 1'b1;
      end
    end else if (pending_r && transfer_s) begin
      a_r       <= a_sh_r;
      b_r       <= b_sh_r;
      sum_r     <= sum_sh_r;
      diff_r    <= diff_sh_r;
      pending_r <= 1'b0;
    end else begin
      pending_r <= pending_r;
    end
  end

  assign A          = a_r;
  assign B          = b_r;
  assign AplusB     = sum_r;
  assign AminusB    = diff_r;
  assign anode      = anode_r;
  assign frame_tick = frame_tick_r;
  assign pending    = pending_r;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl with SUB_CYCLES=4,
// DEAD_CYCLES=1 (slot 64 cycles, frame 256 cycles). Each driven cycle runs a
// behavioural model indexed by the position inside the frame and queues the
// expected outputs; scenario tasks pop and compare after the edge.
module tb_seven_seg_scan_ctrl;

  localparam int SUB   = 4;
  localparam int DEAD  = 1;
  localparam int SLOT  = 16 * SUB;
  localparam int FRAME = 4 * SLOT;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] dig_mask;
  logic [3:0] bright;
  logic       load;
  logic [3:0] a_in, b_in, sum_in, diff_in;
  logic [3:0] a_o, b_o, sum_o, diff_o;
  logic [3:0] anode;
  logic       frame_tick;
  logic       pending;

  seven_seg_scan_ctrl #(.SUB_CYCLES(SUB), .DEAD_CYCLES(DEAD)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .dig_mask   (dig_mask),
    .bright     (bright),
    .load       (load),
    .A_in       (a_in),
    .B_in       (b_in),
    .AplusB_in  (sum_in),
    .AminusB_in (diff_in),
    .A          (a_o),
    .B          (b_o),
    .AplusB     (sum_o),
    .AminusB    (diff_o),
    .anode      (anode),
    .frame_tick (frame_tick),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [15:0] disp_o = {a_o, b_o, sum_o, diff_o};
  wire [21:0] obs    = {anode, frame_tick, pending, a_o, b_o, sum_o, diff_o};

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state
  int          m_t = 0;
  logic [3:0]  m_anode = 4'hF;
  logic        m_tick = 1'b0;
  logic        m_pend = 1'b0;
  logic [15:0] m_disp = 16'h0;
  logic [15:0] m_shadow = 16'h0;
  logic [21:0] exp_q[$];
  logic [21:0] exp_v;

  // Drive one cycle of inputs, advance the model, queue the expectation,
  // then wait for the edge and settle.
  task automatic step(input logic r, input logic e, input logic [3:0] m,
                      input logic [3:0] br, input logic ld, input logic [15:0] v);
    int   dig, ph, sub;
    logic lit, bnd, xfer;
    rst = r; en = e; dig_mask = m; bright = br; load = ld;
    {a_in, b_in, sum_in, diff_in} = v;
    if (r) begin
      m_t = 0; m_anode = 4'hF; m_tick = 1'b0; m_pend = 1'b0;
      m_disp = 16'h0; m_shadow = 16'h0;
    end else begin
      dig = m_t / SLOT;
      ph  = (m_t % SLOT) / SUB;
      sub = m_t % SUB;
      lit = e && m[dig] && (ph <= int'(br)) && !(ph == 0 && sub < DEAD);
      m_anode = lit ? ~(4'b0001 << dig) : 4'b1111;
      bnd  = e && (m_t == FRAME - 1);
      xfer = bnd || !e;
      m_tick = bnd;
      if (ld) begin
        m_shadow = v;
        if (xfer) begin m_disp = v; m_pend = 1'b0; end
        else m_pend = 1'b1;
      end else if (m_pend && xfer) begin
        m_disp = m_shadow; m_pend = 1'b0;
      end
      m_t = (!e || bnd) ? 0 : m_t + 1;
    end
    exp_q.push_back({m_anode, m_tick, m_pend, m_disp});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 16'hFFFF);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
    end
  endtask

  task automatic test_scan_full();
    int ticks = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 1'b1, 4'hF, 4'd15, 1'b0, 16'h0);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL scan cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      if (frame_tick === 1'b1) ticks++;
    end
    n_checks++;
    if (ticks == 2) n_pass++;
    else $display("FAIL scan_ticks got=%0d exp=2", ticks);
  endtask

  task automatic test_brightness();
    logic [3:0] levels[2];
    int         lit_exp[2];
    levels[0] = 4'd3; lit_exp[0] = 60;
    levels[1] = 4'd0; lit_exp[1] = 12;
    for (int k = 0; k < 2; k++) begin
      int lit_cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
        step(1'b0, 1'b1, 4'hF, levels[k], 1'b0, 16'h0);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL bright%0d cyc=%0d got=%h exp=%h", levels[k], cyc, obs, exp_v);
        if (anode !== 4'hF) lit_cnt++;
      end
      n_checks++;
      if (lit_cnt == lit_exp[k]) n_pass++;
      else $display("FAIL bright%0d_lit got=%0d exp=%0d", levels[k], lit_cnt, lit_exp[k]);
    end
  endtask

  task automatic test_mask();
    int odd_lit = 0;
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 1'b1, 4'b0101, 4'd15, 1'b0, 16'h0);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL mask cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      if (anode === 4'b1101 || anode === 4'b0111) odd_lit++;
    end
    n_checks++;
    if (odd_lit == 0) n_pass++;
    else $display("FAIL mask_odd got=%0d exp=0", odd_lit);
  endtask

  task automatic test_load();
    step(1'b1, 1'b0, 4'hF, 4'd15, 1'b0, 16'h0);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL load_rst cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1, 4'hF, 4'd15, (i == 10), (i == 10) ? 16'h5AF0 : 16'h1111);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL load cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
    end
    n_checks++;
    if (disp_o === 16'h5AF0 && pending === 1'b0) n_pass++;
    else $display("FAIL load_final got=%h/%b exp=5af0/0", disp_o, pending);
  endtask

  task automatic test_back_to_back();
    int guard = 0;
    while (m_t != FRAME - 1 && guard < 300) begin
      step(1'b0, 1'b1, 4'hF, 4'd15, 1'b0, 16'h0);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL bnd_wait cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      guard++;
    end
    step(1'b0, 1'b1, 4'hF, 4'd15, 1'b1, 16'h1234);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL bnd_load cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
    n_checks++;
    if (disp_o === 16'h1234 && pending === 1'b0 && frame_tick === 1'b1) n_pass++;
    else $display("FAIL bnd_direct got=%h/%b/%b exp=1234/0/1", disp_o, pending, frame_tick);
    for (int i = 0; i < FRAME; i++) begin
      logic        ld;
      logic [15:0] v;
      ld = (i == 20) || (i == 100);
      v  = (i == 20) ? 16'h6789 : 16'h9ABC;
      step(1'b0, 1'b1, 4'hF, 4'd15, ld, v);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL dbl cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      if (i == 200) begin
        n_checks++;
        if (disp_o === 16'h1234 && pending === 1'b1) n_pass++;
        else $display("FAIL dbl_hold got=%h/%b exp=1234/1", disp_o, pending);
      end
    end
    n_checks++;
    if (disp_o === 16'h9ABC && pending === 1'b0) n_pass++;
    else $display("FAIL dbl_final got=%h/%b exp=9abc/0", disp_o, pending);
  endtask

  task automatic test_reset_mid_and_disable();
    for (int i = 0; i < 24; i++) begin
      step((i == 20), 1'b1, 4'hF, 4'd15, (i == 5) || (i == 20), 16'hBEEF);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL rst_mid cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      if (i == 20) begin
        n_checks++;
        if (obs === 22'h3C0000) n_pass++;
        else $display("FAIL rst_vals got=%h exp=3c0000", obs);
      end
    end
    for (int i = 0; i < 40; i++) begin
      logic e;
      e = !(i == 30 || i == 31);
      step(1'b0, e, 4'hF, 4'd15, (i == 25), 16'hC3A7);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL en_drop cyc=%0d got=%h exp=%h", cyc, obs, exp_v);
      if (i == 30) begin
        n_checks++;
        if (disp_o === 16'hC3A7 && pending === 1'b0 && anode === 4'hF) n_pass++;
        else $display("FAIL en_xfer got=%h/%b/%h exp=c3a7/0/f", disp_o, pending, anode);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_full();
    test_brightness();
    test_mask();
    test_load();
    test_back_to_back();
    test_reset_mid_and_disable();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
